uart_param_top: RTL

Parametrised UART core: configurable data width and baud rate, deterministic TX bit timing, a 16x-oversampled RX with false-start rejection, and frame and overrun error flags. It also has a runtime internal loopback mode that replaces the fixed TX→RX loopback wiring. The core sits between the system bus logic and the serial pins, and is the drop-in successor for the fixed 8-bit loopback UART top.

---
 rtl/uart_param_top.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_param_top.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_param_top
//
// Parametrised UART core. It has a deterministic transmitter and a
// 16x-oversampled receiver with false-start rejection and frame/overrun error
// flags. A runtime loopback input routes the internal TX line into the
// receiver in place of the rxd pin.
//
// Optional feature macro: UART_PARITY_EN
//   defined   : a parity bit follows the data bits (even when PARITY_ODD=0,
//               odd when PARITY_ODD=1), and the receiver checks it.
//   undefined : no parity state exists; rx_parity_err is tied low.
//
// Parameters
//   CLK_FREQ   clock frequency in Hz
//   BAUD       line rate in bit/s; DIV = CLK_FREQ/(BAUD*16) must be >= 2
//   DATA_BITS  payload bits per frame, 5..8
//   PARITY_ODD 0 = even parity, 1 = odd parity (parity builds only)
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous active-low reset
//   tx_data        word to transmit
//   tx_valid       transmit request
//   tx_ready       transmitter idle; the word is accepted on tx_valid&&tx_ready
//   rx_data        last received word
//   rx_valid       unread word present (sticky until rx_clr)
//   rx_clr         clears rx_valid and all RX error flags at the next edge
//   rx_frame_err   a stop bit was sampled low (sticky)
//   rx_parity_err  parity mismatch (sticky)
//   rx_overrun     a word completed while rx_valid was set (sticky)
//   loopback       1 = internal TX feeds RX, txd held high, rxd ignored
//   rxd            serial input, idles high
//   txd            serial output, idles high
// -----------------------------------------------------------------------------
module uart_param_top #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 115_200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_clr,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 rx_overrun,
    input  logic                 loopback,
    input  logic                 rxd,
    output logic                 txd
);

    // One tick = DIV clocks; one bit = 16 ticks.
    localparam int                DIV      = CLK_FREQ / (BAUD * 16);
    localparam int                DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(DIV - 1);
    localparam int                BIT_W    = $clog2(DATA_BITS);
    localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_BITS - 1);

`ifdef UART_PARITY_EN
    localparam logic PAR_ODD = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
    } rx_state_t;
`else
    typedef enum logic [1:0] {
        TX_IDLE, TX_START, TX_DATA, TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE, RX_START, RX_DATA, RX_STOP
    } rx_state_t;

    // PARITY_ODD has no effect without parity.
    logic w_unused_parity_odd;
    assign w_unused_parity_odd = (PARITY_ODD != 0);
`endif

    // =========================================================================
    // Transmitter
    // =========================================================================
    tx_state_t            r_tx_state, w_tx_state_next;
    logic [DIV_W-1:0]     r_tx_div,   w_tx_div_next;
    logic [3:0]           r_tx_tick,  w_tx_tick_next;
    logic [BIT_W-1:0]     r_tx_bit,   w_tx_bit_next;
    logic [DATA_BITS-1:0] r_tx_shift, w_tx_shift_next;
    logic                 r_txd,      w_txd_next;
    logic                 w_tx_bit_end;
`ifdef UART_PARITY_EN
    logic                 r_tx_par,   w_tx_par_next;
`endif

    // Last clock of the current bit: every TX state lasts exactly 16*DIV clocks.
    assign w_tx_bit_end = (r_tx_div == DIV_LAST) && (r_tx_tick == 4'hF);

    // NOTE: every signal driven here gets a default before the case statement,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_tx_state_next = r_tx_state;
        w_tx_div_next   = (r_tx_div == DIV_LAST) ? '0 : r_tx_div + DIV_W'(1);
        w_tx_tick_next  = (r_tx_div == DIV_LAST) ? r_tx_tick + 4'd1 : r_tx_tick;
        w_tx_bit_next   = r_tx_bit;
        w_tx_shift_next = r_tx_shift;
        w_txd_next      = r_txd;
`ifdef UART_PARITY_EN
        w_tx_par_next   = r_tx_par;
`endif

        case (r_tx_state)
            TX_IDLE: begin
                // The divider is parked at zero so an accept restarts bit timing.
                w_tx_div_next  = '0;
                w_tx_tick_next = '0;
                w_txd_next     = 1'b1;
                if (tx_valid) begin
                    w_tx_state_next = TX_START;
                    w_tx_shift_next = tx_data;
                    w_tx_bit_next   = '0;
                    w_txd_next      = 1'b0;
`ifdef UART_PARITY_EN
                    w_tx_par_next   = (^tx_data) ^ PAR_ODD;
`endif
                end
            end

            TX_START: begin
                if (w_tx_bit_end) begin
                    w_tx_state_next = TX_DATA;
                    w_txd_next      = r_tx_shift[0];
                end
            end

            TX_DATA: begin
                if (w_tx_bit_end) begin
                    w_tx_shift_next = r_tx_shift >> 1;
                    if (r_tx_bit == BIT_LAST) begin
`ifdef UART_PARITY_EN
                        w_tx_state_next = TX_PARITY;
                        w_txd_next      = r_tx_par;
`else
                        w_tx_state_next = TX_STOP;
                        w_txd_next      = 1'b1;
`endif
                    end else begin
                        w_tx_bit_next = r_tx_bit + BIT_W'(1);
                        w_txd_next    = r_tx_shift[1];
                    end
                end
            end

`ifdef UART_PARITY_EN
            TX_PARITY: begin
                if (w_tx_bit_end) begin
                    w_tx_state_next = TX_STOP;
                    w_txd_next      = 1'b1;
                end
            end
`endif

            TX_STOP: begin
                if (w_tx_bit_end) begin
                    w_tx_state_next = TX_IDLE;
                    w_txd_next      = 1'b1;
                end
            end

            default: begin
                w_tx_state_next = TX_IDLE;
                w_txd_next      = 1'b1;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx_state <= TX_IDLE;
            r_tx_div   <= '0;
            r_tx_tick  <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_txd      <= 1'b1;
`ifdef UART_PARITY_EN
            r_tx_par   <= 1'b0;
`endif
        end else begin
            r_tx_state <= w_tx_state_next;
            r_tx_div   <= w_tx_div_next;
            r_tx_tick  <= w_tx_tick_next;
            r_tx_bit   <= w_tx_bit_next;
            r_tx_shift <= w_tx_shift_next;
            r_txd      <= w_txd_next;
`ifdef UART_PARITY_EN
            r_tx_par   <= w_tx_par_next;
`endif
        end
    end

    assign tx_ready = (r_tx_state == TX_IDLE);
    assign txd      = loopback ? 1'b1 : r_txd;

    // =========================================================================
    // Receiver
    // =========================================================================
    logic w_line_in;
    logic r_sync1, r_sync2;

    assign w_line_in = loopback ? r_txd : rxd;

    // NOTE: the synchroniser resets to the idle-high line level so that
    // leaving reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= w_line_in;
            r_sync2 <= r_sync1;
        end
    end

    rx_state_t            r_rx_state, w_rx_state_next;
    logic [DIV_W-1:0]     r_rx_div,   w_rx_div_next;
    logic [3:0]           r_rx_tick,  w_rx_tick_next;
    logic [BIT_W-1:0]     r_rx_bit,   w_rx_bit_next;
    logic [DATA_BITS-1:0] r_rx_shift, w_rx_shift_next;
    logic                 w_rx_tick;
    logic                 w_rx_bit_end;
    logic                 w_rx_done;
    logic                 w_rx_stop_bad;
`ifdef UART_PARITY_EN
    logic                 r_rx_par,   w_rx_par_next;
`endif

    assign w_rx_tick    = (r_rx_div == DIV_LAST);
    assign w_rx_bit_end = w_rx_tick && (r_rx_tick == 4'hF);

    always_comb begin
        w_rx_state_next = r_rx_state;
        w_rx_div_next   = w_rx_tick ? '0 : r_rx_div + DIV_W'(1);
        w_rx_tick_next  = w_rx_tick ? r_rx_tick + 4'd1 : r_rx_tick;
        w_rx_bit_next   = r_rx_bit;
        w_rx_shift_next = r_rx_shift;
        w_rx_done       = 1'b0;
        w_rx_stop_bad   = 1'b0;
`ifdef UART_PARITY_EN
        w_rx_par_next   = r_rx_par;
`endif

        case (r_rx_state)
            RX_IDLE: begin
                w_rx_div_next  = '0;
                w_rx_tick_next = '0;
                if (!r_sync2) begin
                    w_rx_state_next = RX_START;
                end
            end

            RX_START: begin
                // Eighth tick is mid start bit; a high line here was a glitch.
                if (w_rx_tick && (r_rx_tick == 4'd7)) begin
                    if (r_sync2) begin
                        w_rx_state_next = RX_IDLE;
                    end else begin
                        w_rx_state_next = RX_DATA;
                        w_rx_tick_next  = '0;
                        w_rx_bit_next   = '0;
                    end
                end
            end

            RX_DATA: begin
                // LSB arrives first, so shift in from the top.
                if (w_rx_bit_end) begin
                    w_rx_shift_next = {r_sync2, r_rx_shift[DATA_BITS-1:1]};
                    if (r_rx_bit == BIT_LAST) begin
`ifdef UART_PARITY_EN
                        w_rx_state_next = RX_PARITY;
`else
                        w_rx_state_next = RX_STOP;
`endif
                    end else begin
                        w_rx_bit_next = r_rx_bit + BIT_W'(1);
                    end
                end
            end

`ifdef UART_PARITY_EN
            RX_PARITY: begin
                if (w_rx_bit_end) begin
                    w_rx_par_next   = r_sync2;
                    w_rx_state_next = RX_STOP;
                end
            end
`endif

            RX_STOP: begin
                if (w_rx_bit_end) begin
                    w_rx_state_next = RX_IDLE;
                    w_rx_done       = 1'b1;
                    w_rx_stop_bad   = !r_sync2;
                end
            end

            default: begin
                w_rx_state_next = RX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_state <= RX_IDLE;
            r_rx_div   <= '0;
            r_rx_tick  <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
`ifdef UART_PARITY_EN
            r_rx_par   <= 1'b0;
`endif
        end else begin
            r_rx_state <= w_rx_state_next;
            r_rx_div   <= w_rx_div_next;
            r_rx_tick  <= w_rx_tick_next;
            r_rx_bit   <= w_rx_bit_next;
            r_rx_shift <= w_rx_shift_next;
`ifdef UART_PARITY_EN
            r_rx_par   <= w_rx_par_next;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Received word and sticky status. rx_clr clears first; a completing word
    // is then applied on top, so a simultaneous completion wins and its flags
    // describe only the new word.
    // -------------------------------------------------------------------------
    logic [DATA_BITS-1:0] r_rx_data, w_rx_data_next;
    logic                 r_rx_valid, w_rx_valid_next;
    logic                 r_rx_frame_err, w_rx_frame_err_next;
    logic                 r_rx_overrun, w_rx_overrun_next;
`ifdef UART_PARITY_EN
    logic                 r_rx_parity_err, w_rx_parity_err_next;
`endif

    always_comb begin
        w_rx_data_next      = r_rx_data;
        w_rx_valid_next     = r_rx_valid     & ~rx_clr;
        w_rx_frame_err_next = r_rx_frame_err & ~rx_clr;
        w_rx_overrun_next   = r_rx_overrun   & ~rx_clr;
`ifdef UART_PARITY_EN
        w_rx_parity_err_next = r_rx_parity_err & ~rx_clr;
`endif
        if (w_rx_done) begin
            w_rx_data_next      = r_rx_shift;
            w_rx_valid_next     = 1'b1;
            w_rx_frame_err_next = w_rx_frame_err_next | w_rx_stop_bad;
            w_rx_overrun_next   = w_rx_overrun_next | (r_rx_valid & ~rx_clr);
`ifdef UART_PARITY_EN
            w_rx_parity_err_next = w_rx_parity_err_next
                                 | (r_rx_par != ((^r_rx_shift) ^ PAR_ODD));
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_data      <= '0;
            r_rx_valid     <= 1'b0;
            r_rx_frame_err <= 1'b0;
            r_rx_overrun   <= 1'b0;
`ifdef UART_PARITY_EN
            r_rx_parity_err <= 1'b0;
`endif
        end else begin
            r_rx_data      <= w_rx_data_next;
            r_rx_valid     <= w_rx_valid_next;
            r_rx_frame_err <= w_rx_frame_err_next;
            r_rx_overrun   <= w_rx_overrun_next;
`ifdef UART_PARITY_EN
            r_rx_parity_err <= w_rx_parity_err_next;
`endif
        end
    end

    assign rx_data      = r_rx_data;
    assign rx_valid     = r_rx_valid;
    assign rx_frame_err = r_rx_frame_err;
    assign rx_overrun   = r_rx_overrun;
`ifdef UART_PARITY_EN
    assign rx_parity_err = r_rx_parity_err;
`else
    assign rx_parity_err = 1'b0;
`endif

endmodule
